// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter, open-drain pull-low enables.
// Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 12000,
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

`ifdef PS2_TX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RELEASE,
      SHIFT,
      ACK,
      WAIT_IDLE
   } state_t;

   state_t state, state_n;

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          clk_s;
   logic          dat_s;
   logic          clk_f;
   logic [FW-1:0] flt_cnt;
   logic          fall;

   logic [IW-1:0] inh_cnt, inh_n;
   logic [3:0]    bit_cnt, bit_n;
   logic [9:0]    frame, frame_n;
   logic [TW-1:0] wd_cnt, wd_n;
   logic          clk_oe_q, clk_oe_n;
   logic          data_oe_q, data_oe_n;
   logic          done, err;
   logic          wd_on;
   logic          wd_hit;

   assign clk_s = clk_sync[1];
   assign dat_s = dat_sync[1];

   // Clock level must differ for FILTER_LEN samples in a row to be taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_f    <= 1'b1;
         flt_cnt  <= '0;
         fall     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk_in};
         dat_sync <= {dat_sync[0], ps2_data_in};
         fall     <= 1'b0;
         if (clk_s == clk_f) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_f   <= clk_s;
            flt_cnt <= '0;
            fall    <= clk_f;
         end else begin
            flt_cnt <= flt_cnt + FW'(1);
         end
      end
   end

   assign wd_on  = (state != IDLE) && (state != INHIBIT);
   assign wd_hit = TO_EN && wd_on &&
                   (wd_cnt == TW'(TIMEOUT_CYCLES));

   always_comb begin
      state_n   = state;
      inh_n     = inh_cnt;
      bit_n     = bit_cnt;
      frame_n   = frame;
      clk_oe_n  = clk_oe_q;
      data_oe_n = data_oe_q;
      wd_n      = wd_cnt;
      done      = 1'b0;
      err       = 1'b0;
      if (wd_on) begin
         wd_n = wd_cnt + TW'(1);
      end
      unique case (state)
         IDLE: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            if (tx_valid) begin
               state_n  = INHIBIT;
               inh_n    = '0;
               clk_oe_n = 1'b1;
               frame_n  = {1'b1, ~^tx_data, tx_data};
            end
         end
         INHIBIT: begin
            inh_n = inh_cnt + IW'(1);
            wd_n  = '0;
            // Start bit goes low during the final inhibit cycle.
            if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) begin
               data_oe_n = 1'b1;
            end
            if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
               state_n  = RELEASE;
               clk_oe_n = 1'b0;
            end
         end
         RELEASE: begin
            bit_n   = '0;
            state_n = SHIFT;
         end
         SHIFT: begin
            if (fall) begin
               data_oe_n = ~frame[0];
               frame_n   = {1'b1, frame[9:1]};
               bit_n     = bit_cnt + 4'd1;
               if (bit_cnt == 4'd9) begin
                  state_n = ACK;
               end
            end
         end
         ACK: begin
            if (fall) begin
               if (dat_s) begin
                  err     = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (clk_s && dat_s) begin
               done    = 1'b1;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      if (wd_hit) begin
         state_n   = IDLE;
         clk_oe_n  = 1'b0;
         data_oe_n = 1'b0;
         err       = 1'b1;
         done      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         inh_cnt   <= '0;
         bit_cnt   <= '0;
         frame     <= '0;
         wd_cnt    <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
      end else begin
         state     <= state_n;
         inh_cnt   <= inh_n;
         bit_cnt   <= bit_n;
         frame     <= frame_n;
         wd_cnt    <= wd_n;
         clk_oe_q  <= clk_oe_n;
         data_oe_q <= data_oe_n;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_ready    = (state == IDLE);
   assign tx_busy     = (state != IDLE);
   assign tx_done     = done;
   assign tx_error    = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-side model clocks frames out of ps2_host_tx.
// Expected frames come from a byte-level model (LSB first, odd parity, stop).
module tb_ps2_host_tx;

   localparam int INH  = 600;
   localparam int TMO  = 5000;
   localparam int FLT  = 8;
   localparam int HALF = 40;

   typedef struct {
      logic [7:0] d;
      bit         ack;
      bit         gl;
      bit         exp_par;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       glitch = 1'b0;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       tx_ready, tx_busy, tx_done, tx_error;
   logic       data_line;
   logic       busy_q = 1'b0;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int starts = 0;
   int overlap = 0;
   int exp_starts = 0;

   always #5 clk = ~clk;

   assign data_line   = dev_data & ~ps2_data_oe;
   assign ps2_data_in = data_line;
   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe & ~glitch;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO),
      .FILTER_LEN(FLT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
      .ps2_clk_in(ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .tx_ready(tx_ready),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .tx_error(tx_error)
   );

   always @(negedge clk) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done && tx_error) overlap++;
      if (tx_busy && !busy_q) starts++;
      busy_q = tx_busy;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [9:0] model_frame(input logic [7:0] d);
      int ones = 0;
      for (int k = 0; k < 8; k++) ones += int'(d[k]);
      return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
   endfunction

   task automatic send_req(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      exp_starts++;
      chk("accept_busy", tx_busy, 1);
      chk("accept_ready", tx_ready, 0);
   endtask

   task automatic check_inhibit();
      int n = 0;
      logic last_d = 1'b0;
      while (ps2_clk_oe && n < INH + 100) begin
         last_d = ps2_data_oe;
         n++;
         @(negedge clk);
      end
      chk("inhibit_len", n, INH);
      chk("start_in_inhibit", last_d, 1);
      chk("start_bit_line", data_line, 0);
   endtask

   task automatic wait_release();
      int n = 0;
      while (ps2_clk_oe && n < INH + 100) begin
         n++;
         @(negedge clk);
      end
      chk("release_seen", ps2_clk_oe, 0);
   endtask

   task automatic dev_pulse(input bit gl, output logic b);
      if (gl) begin
         repeat (HALF / 2) @(negedge clk);
         glitch = 1'b1;
         repeat (3) @(negedge clk);
         glitch = 1'b0;
         repeat (HALF - HALF / 2 - 3) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      b = data_line;
      dev_clk = 1'b1;
   endtask

   task automatic dev_frame(input logic [7:0] d, input bit ack,
                            input bit gl, input bit idle_chk,
                            output logic [9:0] got);
      int dc0 = done_cnt;
      int ec0 = err_cnt;
      int n = 0;
      logic b;
      repeat (20) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         dev_pulse(gl, b);
         got[i] = b;
      end
      dev_data = ack ? 1'b0 : 1'b1;
      dev_pulse(gl, b);
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
      while (done_cnt == dc0 && err_cnt == ec0 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk($sformatf("frame_%02h", d), got, model_frame(d));
      chk("done_pulses", done_cnt - dc0, ack ? 1 : 0);
      chk("error_pulses", err_cnt - ec0, ack ? 0 : 1);
      if (idle_chk) begin
         chk("ready_after", tx_ready, 1);
         chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
      end
   endtask

   initial begin
      vec_t tbl[5];
      logic [9:0] got;
      logic b;
      logic [7:0] rd;
      bit rack, rgl;
      int s0;

      tbl[0] = '{8'hED, 1'b1, 1'b0, 1'b1};
      tbl[1] = '{8'hF4, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{8'hFF, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{8'hA5, 1'b1, 1'b1, 1'b1};

      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_error", tx_error, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         send_req(tbl[i].d);
         check_inhibit();
         dev_frame(tbl[i].d, tbl[i].ack, tbl[i].gl, 1'b1, got);
         chk($sformatf("parity_%02h", tbl[i].d), got[8], tbl[i].exp_par);
         repeat (20) @(negedge clk);
      end

      for (int i = 0; i < 4; i++) begin
         rd   = 8'($urandom_range(0, 255));
         rack = ($urandom_range(0, 3) != 0);
         rgl  = ($urandom_range(0, 1) == 1);
         send_req(rd);
         check_inhibit();
         dev_frame(rd, rack, rgl, 1'b1, got);
         repeat (20) @(negedge clk);
      end

      // Reset while shifting, after the fourth falling edge.
      send_req(8'h3C);
      check_inhibit();
      repeat (20) @(negedge clk);
      for (int i = 0; i < 3; i++) dev_pulse(1'b0, b);
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_clk_oe", ps2_clk_oe, 0);
      chk("midrst_data_oe", ps2_data_oe, 0);
      chk("midrst_ready", tx_ready, 1);
      rst = 1'b0;
      dev_clk = 1'b1;
      repeat (50) @(negedge clk);
      send_req(8'hFF);
      check_inhibit();
      dev_frame(8'hFF, 1'b1, 1'b0, 1'b1, got);
      chk("parity_ff_after_rst", got[8], 1);
      repeat (20) @(negedge clk);

      // tx_valid held high across a whole transfer.
      s0 = starts;
      @(negedge clk);
      tx_data  = 8'hED;
      tx_valid = 1'b1;
      @(negedge clk);
      exp_starts += 2;
      check_inhibit();
      chk("held_one_start", starts - s0, 1);
      dev_frame(8'hED, 1'b1, 1'b0, 1'b0, got);
      chk("held_restart", starts - s0, 2);
      tx_valid = 1'b0;
      wait_release();
      dev_frame(8'hED, 1'b1, 1'b0, 1'b1, got);
      repeat (20) @(negedge clk);

`ifdef PS2_TX_TIMEOUT_EN
      begin
         int n = 0;
         int ec0 = err_cnt;
         send_req(8'h12);
         check_inhibit();
         while (!tx_error && n < TMO + 1000) begin
            @(negedge clk);
            n++;
         end
         chk("timeout_cycles", n, TMO);
         repeat (5) @(negedge clk);
         chk("timeout_error", err_cnt - ec0, 1);
         chk("timeout_released", {ps2_clk_oe, ps2_data_oe}, 0);
         chk("timeout_ready", tx_ready, 1);
      end
`endif

      chk("done_error_overlap", overlap, 0);
      chk("transfers_started", starts, exp_starts);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
